// File: rtl/aes_pkg.sv
// Shared AES helpers: key-size encoding, round-constant bounds and GF(2^8) step functions.
// Used by the rcon sequencer, key expansion and MixColumns.
package aes_pkg;

    typedef enum logic [1:0] {
        Aes128 = 2'b00,
        Aes192 = 2'b01,
        Aes256 = 2'b10
    } aes_mode_e;

    // Indexed by the raw mode field; the reserved code 11 aliases AES-128.
    localparam logic [3:0] RCON_N    [4] = '{4'd10, 4'd8, 4'd7, 4'd10};
    localparam logic [7:0] RCON_LAST [4] = '{8'h36, 8'h80, 8'h40, 8'h36};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] xinv(input logic [7:0] b);
        return {1'b0, b[7:1]} ^ (b[0] ? 8'h8d : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_seq.sv
// AES round-constant sequencer: forward or reverse rcon stream for AES-128/192/256,
// stepped by an explicit advance strobe. busy/last double as the IDLE/RUN/FINAL state.
module aes_rcon_seq
    import aes_pkg::*;
#(
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kld,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             adv,
    output logic [OUT_W-1:0] out,
    output logic [3:0]       rnd,
    output logic             last,
    output logic             busy
);

    logic [7:0] byte_q, byte_d;
    logic [3:0] rnd_q, rnd_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;
    aes_mode_e  mode_q, mode_d;
    logic       dir_q, dir_d;
    aes_mode_e  mode_in;

    assign mode_in = (mode == 2'b11) ? Aes128 : aes_mode_e'(mode);

    always_comb begin
        byte_d = byte_q;
        rnd_d  = rnd_q;
        last_d = last_q;
        busy_d = busy_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        if (kld) begin
            mode_d = mode_in;
            dir_d  = dir;
            busy_d = 1'b1;
            last_d = 1'b0;
            byte_d = dir ? RCON_LAST[mode_in] : 8'h01;
            rnd_d  = dir ? RCON_N[mode_in] : 4'd1;
        end else if (adv && busy_q) begin
            if (last_q) begin
                byte_d = 8'h00;
                rnd_d  = 4'd0;
                last_d = 1'b0;
                busy_d = 1'b0;
            end else if (dir_q) begin
                byte_d = xinv(byte_q);
                rnd_d  = rnd_q - 4'd1;
                last_d = (rnd_d == 4'd1);
            end else begin
                byte_d = xtime(byte_q);
                rnd_d  = rnd_q + 4'd1;
                last_d = (rnd_d == RCON_N[mode_q]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_q <= 8'h00;
            rnd_q  <= 4'd0;
            last_q <= 1'b0;
            busy_q <= 1'b0;
            mode_q <= Aes128;
            dir_q  <= 1'b0;
        end else begin
            byte_q <= byte_d;
            rnd_q  <= rnd_d;
            last_q <= last_d;
            busy_q <= busy_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
        end
    end

    always_comb begin
        out                = '0;
        out[OUT_W-1 -: 8]  = byte_q;
    end

    assign rnd  = rnd_q;
    assign last = last_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Bench for aes_rcon_seq: directed vector table for the corner cases, then random
// stimulus checked against a step-count model over the published rcon list.
module tb_aes_rcon_seq;

    logic        clk = 1'b0;
    logic        rst_n, kld, dir, adv;
    logic [1:0]  mode;
    logic [31:0] out;
    logic [3:0]  rnd;
    logic        last, busy;

    int n_vec  = 0;
    int n_fail = 0;

    aes_rcon_seq #(.OUT_W(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kld  (kld),
        .mode (mode),
        .dir  (dir),
        .adv  (adv),
        .out  (out),
        .rnd  (rnd),
        .last (last),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       kld;
        logic [1:0] mode;
        logic       dir;
        logic       adv;
        logic [7:0] b;
        logic [3:0] r;
        logic       l;
        logic       bz;
    } vec_t;

    vec_t vecs[$];

    // The ten AES round constants, rcon[1..10].
    logic [7:0] rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    task automatic v(input string name, input logic r_n, input logic k, input logic [1:0] m,
                     input logic d, input logic a, input logic [7:0] b, input logic [3:0] r,
                     input logic l, input logic bz);
        vec_t e;
        e.name = name; e.rst_n = r_n; e.kld = k; e.mode = m; e.dir = d; e.adv = a;
        e.b = b; e.r = r; e.l = l; e.bz = bz;
        vecs.push_back(e);
    endtask

    task automatic apply(input logic r_n, input logic k, input logic [1:0] m, input logic d,
                         input logic a);
        rst_n = r_n; kld = k; mode = m; dir = d; adv = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] eb, input logic [3:0] er,
                         input logic el, input logic ebz);
        logic [31:0] eo;
        eo = {eb, 24'h0};
        n_vec++;
        if (out !== eo || rnd !== er || last !== el || busy !== ebz) begin
            n_fail++;
            $display("FAIL %s: got out=%h rnd=%0d last=%b busy=%b, want out=%h rnd=%0d last=%b busy=%b",
                     name, out, rnd, last, busy, eo, er, el, ebz);
        end
    endtask

    // Reference model: remembers only how many steps have been taken.
    int  m_busy, m_n, m_dir, m_k;

    function automatic int n_of(input logic [1:0] m);
        return (m == 2'b01) ? 8 : (m == 2'b10) ? 7 : 10;
    endfunction

    initial begin
        rst_n = 1'b0; kld = 1'b1; mode = 2'b00; dir = 1'b0; adv = 1'b1;

        // Reset dominates kld/adv
        v("reset0", 0, 1, 0, 0, 1, 8'h00, 0, 0, 0);
        v("reset1", 0, 1, 0, 0, 1, 8'h00, 0, 0, 0);
        v("idle_adv", 1, 0, 0, 0, 1, 8'h00, 0, 0, 0);
        // AES-128 forward
        v("a128f_kld", 1, 1, 0, 0, 0, 8'h01, 1, 0, 1);
        for (int i = 1; i < 10; i++)
            v("a128f_adv", 1, 0, 0, 0, 1, rc[i], 4'(i + 1), (i == 9), 1);
        v("a128f_end", 1, 0, 0, 0, 1, 8'h00, 0, 0, 0);
        v("a128f_idle", 1, 0, 0, 0, 1, 8'h00, 0, 0, 0);
        // AES-256 reverse
        v("a256r_kld", 1, 1, 2, 1, 0, 8'h40, 7, 0, 1);
        for (int i = 5; i >= 0; i--)
            v("a256r_adv", 1, 0, 2, 1, 1, rc[i], 4'(i + 1), (i == 0), 1);
        v("a256r_end", 1, 0, 2, 1, 1, 8'h00, 0, 0, 0);
        // AES-192 forward then reverse start
        v("a192f_kld", 1, 1, 1, 0, 0, 8'h01, 1, 0, 1);
        for (int i = 1; i < 8; i++)
            v("a192f_adv", 1, 0, 1, 0, 1, rc[i], 4'(i + 1), (i == 7), 1);
        v("a192r_kld", 1, 1, 1, 1, 0, 8'h80, 8, 0, 1);
        v("stall", 1, 0, 1, 1, 0, 8'h80, 8, 0, 1);
        v("a192r_adv", 1, 0, 1, 1, 1, 8'h40, 7, 0, 1);
        // Restart mid-sequence, kld beats adv
        v("mid_kld", 1, 1, 0, 0, 0, 8'h01, 1, 0, 1);
        for (int i = 1; i < 5; i++)
            v("mid_adv", 1, 0, 0, 0, 1, rc[i], 4'(i + 1), 0, 1);
        v("kld_adv", 1, 1, 0, 0, 1, 8'h01, 1, 0, 1);
        v("kld_adv_n", 1, 0, 0, 0, 1, 8'h02, 2, 0, 1);
        v("rst_kld", 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        // Reserved mode, and mode/dir changes ignored mid-sequence
        v("m3_fwd", 1, 1, 3, 0, 0, 8'h01, 1, 0, 1);
        v("m3_rev", 1, 1, 3, 1, 0, 8'h36, 10, 0, 1);
        v("tog1", 1, 0, 2, 0, 1, 8'h1b, 9, 0, 1);
        v("tog2", 1, 0, 1, 0, 1, 8'h80, 8, 0, 1);
        v("tog3", 1, 0, 2, 0, 1, 8'h40, 7, 0, 1);
        v("final_kld", 1, 1, 2, 0, 0, 8'h01, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst_n, vecs[i].kld, vecs[i].mode, vecs[i].dir, vecs[i].adv);
            check(vecs[i].name, vecs[i].b, vecs[i].r, vecs[i].l, vecs[i].bz);
        end

        m_busy = 0; m_n = 10; m_dir = 0; m_k = 0;
        for (int c = 0; c < 3000; c++) begin
            logic       r_n, k, d, a;
            logic [1:0] m;
            logic [7:0] eb;
            logic [3:0] er;
            logic       el;
            r_n = (c == 0) ? 1'b0 : ($urandom_range(99) >= 2);
            k   = ($urandom_range(99) < 8);
            a   = ($urandom_range(99) < 65);
            m   = 2'($urandom_range(3));
            d   = 1'($urandom_range(1));
            apply(r_n, k, m, d, a);
            if (!r_n) begin
                m_busy = 0;
            end else if (k) begin
                m_busy = 1; m_n = n_of(m); m_dir = int'(d); m_k = 0;
            end else if (a && m_busy != 0) begin
                if (m_k == m_n - 1) m_busy = 0;
                else m_k++;
            end
            if (m_busy != 0) begin
                er = 4'((m_dir != 0) ? m_n - m_k : m_k + 1);
                eb = rc[er - 4'd1];
                el = (m_k == m_n - 1);
            end else begin
                er = 4'd0; eb = 8'h00; el = 1'b0;
            end
            check("random", eb, er, el, (m_busy != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
